qspi_flash_read_engine: RTL



---
 rtl/qspi_flash_read_engine_pkg.sv | 34 +++
 rtl/qspi_flash_read_engine_sck_phase.sv | 25 ++
 rtl/qspi_flash_read_engine.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/qspi_flash_read_engine_pkg.sv
// Shared constants and types for the quad-I/O fast-read engine.
package qspi_pkg;

    // Quad I/O fast read opcode
    localparam logic [7:0] QSPI_OP_QREAD = 8'hEB;

    // Phase lengths in SCK cycles
    localparam logic [3:0] CMD_SCK  = 4'd8;
    localparam logic [3:0] ADDR_SCK = 4'd6;
    localparam logic [3:0] MODE_SCK = 4'd2;
    localparam logic [3:0] DATA_SCK = 4'd8;

    // Pad output-enable patterns: in CMD io1 is the flash's output, io2/io3 hold WP#/HOLD# high
    localparam logic [3:0] OE_CMD  = 4'b1101;
    localparam logic [3:0] OE_QUAD = 4'b1111;
    localparam logic [3:0] OE_IN   = 4'b0000;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        MODE,
        DUMMY,
        DATA,
        DONE,
        CSH
    } qspi_state_e;

    // Received word holds byte0 in the top byte; the bus wants byte0 in the bottom byte
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/qspi_flash_read_engine_sck_phase.sv
// SCK generator: HCLK/2 toggle with strobes marking the end of each SCK half.
module qspi_sck_phase (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic en,
    output logic spi_clk,
    output logic fall_stb,
    output logic rise_stb
);

    logic ph;

    // Phase toggle: 0 = low half, 1 = high half; parked low whenever disabled
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) ph <= 1'b0;
        else if (en)  ph <= ~ph;
        else          ph <= 1'b0;
    end

    assign spi_clk  = ph;
    // rise_stb: the coming edge raises SCK; fall_stb: the coming edge drops SCK
    assign rise_stb = en & ~ph;
    assign fall_stb = en & ph;

endmodule

// File: rtl/qspi_flash_read_engine.sv
// Quad-I/O (0xEB) single-word read engine driving the serial NOR flash pins.
import qspi_pkg::*;

module qspi_flash_read_engine #(
    parameter int unsigned DUMMY_CYCLES   = 4,
    parameter logic [7:0]  MODE_BYTE      = 8'hFF,
    parameter int unsigned CS_HIGH_CYCLES = 2
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic [23:0] addr,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        spi_clk,
    output logic        spi_cs_n,
    output logic [3:0]  spi_io_o,
    output logic [3:0]  spi_io_oe,
    input  logic [3:0]  spi_io_i
);

    localparam logic [3:0] DUMMY_LD = 4'(DUMMY_CYCLES);
    localparam logic [3:0] CSH_LD   = 4'(CS_HIGH_CYCLES - 1);

    qspi_state_e state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] sr, sr_nxt;
    logic [31:0] rdata_q, rdata_nxt;
    logic [31:0] rx_word;
    logic        sck_en;
    logic        fall_stb;
    logic        rise_stb;

    assign sck_en  = (state == CMD) || (state == ADDR) || (state == MODE) ||
                     (state == DUMMY) || (state == DATA);
    assign rx_word = {sr[27:0], spi_io_i};

    qspi_sck_phase u_sck (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .en       (sck_en),
        .spi_clk  (spi_clk),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    // FSM state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Counter, shared TX/RX shift register and read-data holding register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt     <= '0;
            sr      <= '0;
            rdata_q <= '0;
        end else begin
            cnt     <= cnt_nxt;
            sr      <= sr_nxt;
            rdata_q <= rdata_nxt;
        end
    end

    // Next state: SCK cycles are counted on rise_stb, phases advance on fall_stb once the count is spent
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        rdata_nxt = rdata_q;
        if (rise_stb) cnt_nxt = cnt - 4'd1;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CMD;
                    cnt_nxt   = CMD_SCK;
                    // Opcode then address: after 8 single-bit shifts the address sits at the top
                    sr_nxt    = {QSPI_OP_QREAD, addr};
                end
            end
            CMD: begin
                if (fall_stb) begin
                    sr_nxt = {sr[30:0], 1'b0};
                    if (cnt == 4'd0) begin
                        state_nxt = ADDR;
                        cnt_nxt   = ADDR_SCK;
                    end
                end
            end
            ADDR: begin
                if (fall_stb) begin
                    sr_nxt = {sr[27:0], 4'h0};
                    if (cnt == 4'd0) begin
                        state_nxt = MODE;
                        cnt_nxt   = MODE_SCK;
                        sr_nxt    = {MODE_BYTE, 24'h0};
                    end
                end
            end
            MODE: begin
                if (fall_stb) begin
                    sr_nxt = {sr[27:0], 4'h0};
                    if (cnt == 4'd0) begin
                        state_nxt = DUMMY;
                        cnt_nxt   = DUMMY_LD;
                    end
                end
            end
            DUMMY: begin
                if (fall_stb && cnt == 4'd0) begin
                    state_nxt = DATA;
                    cnt_nxt   = DATA_SCK;
                end
            end
            DATA: begin
                // Sample at the end of the high half, when the flash data is settled
                if (fall_stb) begin
                    sr_nxt = rx_word;
                    if (cnt == 4'd0) begin
                        state_nxt = DONE;
                        rdata_nxt = byte_swap32(rx_word);
                    end
                end
            end
            DONE: begin
                state_nxt = CSH;
                cnt_nxt   = CSH_LD;
            end
            CSH: begin
                if (cnt == 4'd0) state_nxt = IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pad drive: everything derives from registered state/shift data, so it moves only at low-half entry
    always_comb begin
        spi_io_o  = 4'b0000;
        spi_io_oe = OE_IN;
        case (state)
            CMD: begin
                spi_io_o  = {2'b11, 1'b0, sr[31]};
                spi_io_oe = OE_CMD;
            end
            ADDR, MODE: begin
                spi_io_o  = sr[31:28];
                spi_io_oe = OE_QUAD;
            end
            default: begin
                spi_io_o  = 4'b0000;
                spi_io_oe = OE_IN;
            end
        endcase
    end

    assign spi_cs_n = ~sck_en;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign rdata    = rdata_q;

endmodule
